// File: rtl/traceback_ctrl_if.sv
// rtl/traceback_ctrl_if.sv - Direction RAM read port and alignment-op stream for traceback_ctrl
interface traceback_ctrl_if #(
   parameter int N           = 128,
   parameter int addr_lenght = $clog2((N + 1) * (N + 1)),
   parameter int idx_w       = $clog2(N + 1)
);
   logic                   rd_en;
   logic [addr_lenght-1:0] rd_addr;
   logic [2:0]             rd_data;
   logic                   op_valid;
   logic                   op_ready;
   logic [1:0]             op_code;
   logic [idx_w-1:0]       op_i;
   logic [idx_w-1:0]       op_j;

   modport master (
      output rd_en, rd_addr, op_valid, op_code, op_i, op_j,
      input  rd_data, op_ready
   );

   modport slave (
      input  rd_en, rd_addr, op_valid, op_code, op_i, op_j,
      output rd_data, op_ready
   );
endinterface

// File: rtl/traceback_ctrl.sv
// rtl/traceback_ctrl.sv - Needleman-Wunsch traceback sequencer (Direction RAM walk -> op stream)
// Optional accepted-op counter output op_cnt enabled by defining TB_OPCOUNT_EN.
module traceback_ctrl #(
   parameter int N           = 128,
   parameter int addr_lenght = $clog2((N + 1) * (N + 1)),
   parameter int idx_w       = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [idx_w-1:0] len_a,
   input  logic [idx_w-1:0] len_b,
   traceback_ctrl_if.master bus,
   output logic             busy,
   output logic             done,
   output logic             err
`ifdef TB_OPCOUNT_EN
   ,
   output logic [idx_w:0]   op_cnt
`endif
);
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT, S_DONE} state_t;

   localparam logic [1:0] OP_DIAG = 2'b01;
   localparam logic [1:0] OP_UP   = 2'b10;
   localparam logic [1:0] OP_LEFT = 2'b11;

   state_t                 state;
   state_t                 state_nxt;
   logic [idx_w-1:0]       i_r;
   logic [idx_w-1:0]       j_r;
   logic [idx_w-1:0]       i_nxt;
   logic [idx_w-1:0]       j_nxt;
   logic [addr_lenght-1:0] addr_r;
   logic [addr_lenght-1:0] addr_step;
   logic [1:0]             code_r;
   logic [1:0]             dec_code;
   logic                   dec_bad;
   logic                   accept;

   // diag > up > left when several direction bits are set
   always_comb begin
      dec_code = OP_DIAG;
      dec_bad  = 1'b0;
      if (bus.rd_data[2])      dec_code = OP_DIAG;
      else if (bus.rd_data[1]) dec_code = OP_UP;
      else if (bus.rd_data[0]) dec_code = OP_LEFT;
      else                     dec_bad  = 1'b1;
   end

   // Row-major stepping keeps the address incremental: diag -(N+2), up -(N+1), left -1
   always_comb begin
      i_nxt     = i_r;
      j_nxt     = j_r;
      addr_step = '0;
      case (code_r)
         OP_DIAG: begin
            i_nxt     = i_r - idx_w'(1);
            j_nxt     = j_r - idx_w'(1);
            addr_step = addr_lenght'(N + 2);
         end
         OP_UP: begin
            i_nxt     = i_r - idx_w'(1);
            addr_step = addr_lenght'(N + 1);
         end
         OP_LEFT: begin
            j_nxt     = j_r - idx_w'(1);
            addr_step = addr_lenght'(1);
         end
         default: ;
      endcase
   end

   assign accept = (state == S_EMIT) && bus.op_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      bus.rd_en    = 1'b0;
      bus.op_valid = 1'b0;
      bus.op_code  = 2'b00;
      busy         = 1'b0;
      done         = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (len_a == '0 && len_b == '0)      state_nxt = S_DONE;
               else if (len_a == '0 || len_b == '0) state_nxt = S_EMIT;
               else                                 state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            bus.rd_en = 1'b1;
            busy      = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            busy      = 1'b1;
            state_nxt = dec_bad ? S_DONE : S_EMIT;
         end
         S_EMIT: begin
            busy         = 1'b1;
            bus.op_valid = 1'b1;
            bus.op_code  = code_r;
            if (bus.op_ready) begin
               if (i_nxt == '0 && j_nxt == '0)      state_nxt = S_DONE;
               else if (i_nxt == '0 || j_nxt == '0) state_nxt = S_EMIT;
               else                                 state_nxt = S_ISSUE;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.rd_addr = addr_r;
   assign bus.op_i    = i_r;
   assign bus.op_j    = j_r;

   // Boundary cells never read the RAM, so their op code is set here directly
   always_ff @(posedge clk) begin
      if (rst) begin
         i_r    <= '0;
         j_r    <= '0;
         addr_r <= '0;
         code_r <= 2'b00;
         err    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  i_r    <= len_a;
                  j_r    <= len_b;
                  addr_r <= addr_lenght'(len_a) * addr_lenght'(N + 1) + addr_lenght'(len_b);
                  code_r <= (len_a == '0) ? OP_LEFT : OP_UP;
                  err    <= 1'b0;
               end
            end
            S_WAIT: begin
               if (dec_bad) err    <= 1'b1;
               else         code_r <= dec_code;
            end
            S_EMIT: begin
               if (accept) begin
                  i_r    <= i_nxt;
                  j_r    <= j_nxt;
                  addr_r <= addr_r - addr_step;
                  code_r <= (i_nxt == '0) ? OP_LEFT : OP_UP;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef TB_OPCOUNT_EN
   always_ff @(posedge clk) begin
      if (rst)                        op_cnt <= '0;
      else if (state == S_IDLE && start) op_cnt <= '0;
      else if (accept)                op_cnt <= op_cnt + (idx_w + 1)'(1);
   end
`endif
endmodule

// File: tb/tb_traceback_ctrl.sv
// tb/tb_traceback_ctrl.sv - randomized self-checking bench for traceback_ctrl
module tb_traceback_ctrl;
   localparam int N     = 128;
   localparam int IW    = $clog2(N + 1);
   localparam int CELLS = (N + 1) * (N + 1);

   typedef struct packed {
      logic [1:0]    code;
      logic [IW-1:0] i;
      logic [IW-1:0] j;
   } op_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [IW-1:0] len_a;
   logic [IW-1:0] len_b;
   logic          busy;
   logic          done;
   logic          err;
`ifdef TB_OPCOUNT_EN
   logic [IW:0]   op_cnt;
   int            obs_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [2:0] mem [CELLS];
   op_t  exp_ops[$];
   op_t  obs_ops[$];
   int   exp_rd[$];
   int   obs_rd[$];
   logic exp_err;
   int   done_cnt, busy_bad, stall_bad, valid_seen, timed_out;
   logic err_at_done, err_after_start;

   always #5 clk = ~clk;

   traceback_ctrl_if #(.N(N)) bus ();

   traceback_ctrl #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .len_a (len_a),
      .len_b (len_b),
      .bus   (bus),
      .busy  (busy),
      .done  (done),
      .err   (err)
`ifdef TB_OPCOUNT_EN
      ,
      .op_cnt(op_cnt)
`endif
   );

   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
   end

   task automatic fill_mem(input int zero_pct);
      for (int k = 0; k < CELLS; k++)
         mem[k] = (int'($urandom_range(0, 99)) < zero_pct) ? 3'b000 : 3'($urandom_range(1, 7));
   endtask

   // Reference walk: boundary cells step without reading, interior cells decode diag > up > left
   task automatic model_walk(input int la, input int lb);
      int   i;
      int   j;
      int   a;
      logic [2:0] w;
      op_t  o;
      exp_ops.delete();
      exp_rd.delete();
      exp_err = 1'b0;
      i = la;
      j = lb;
      while (i != 0 || j != 0) begin
         o.i = IW'(i);
         o.j = IW'(j);
         if (i == 0) begin
            o.code = 2'b11; j = j - 1;
         end else if (j == 0) begin
            o.code = 2'b10; i = i - 1;
         end else begin
            a = i * (N + 1) + j;
            exp_rd.push_back(a);
            w = mem[a];
            if (w == 3'b000) begin
               exp_err = 1'b1;
               break;
            end
            if (w[2])      begin o.code = 2'b01; i = i - 1; j = j - 1; end
            else if (w[1]) begin o.code = 2'b10; i = i - 1; end
            else           begin o.code = 2'b11; j = j - 1; end
         end
         exp_ops.push_back(o);
      end
   endtask

   task automatic drive_walk(input int la, input int lb, input int rdy_pct, input int stall_n);
      op_t  prev;
      op_t  cur;
      logic prev_hold;
      logic seen_done;
      int   stalls_left;
      int   post;
      obs_ops.delete();
      obs_rd.delete();
      done_cnt = 0; busy_bad = 0; stall_bad = 0; valid_seen = 0; timed_out = 1;
      err_at_done = 1'b0;
      prev = '0; prev_hold = 1'b0; seen_done = 1'b0; stalls_left = stall_n; post = 0;
      @(negedge clk);
      start = 1'b1; len_a = IW'(la); len_b = IW'(lb); bus.op_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      err_after_start = err;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         if (bus.op_valid && stalls_left > 0) begin
            bus.op_ready = 1'b0;
            stalls_left--;
         end else begin
            bus.op_ready = (int'($urandom_range(0, 99)) < rdy_pct);
         end
         cur.code = bus.op_code; cur.i = bus.op_i; cur.j = bus.op_j;
         if (prev_hold && (!bus.op_valid || cur !== prev || bus.rd_en)) stall_bad++;
         if (bus.rd_en) obs_rd.push_back(int'(bus.rd_addr));
         if (bus.op_valid) valid_seen++;
         if (!seen_done && !done && !busy) busy_bad++;
         if (done) begin
            done_cnt++;
            if (busy) busy_bad++;
            if (!seen_done) err_at_done = err;
            seen_done = 1'b1;
         end
         if (bus.op_valid && bus.op_ready) obs_ops.push_back(cur);
         prev_hold = bus.op_valid && !bus.op_ready;
         prev = cur;
         if (seen_done) begin
            post++;
            if (post > 3) begin
               timed_out = 0;
               break;
            end
         end
         @(negedge clk);
      end
      bus.op_ready = 1'b0;
`ifdef TB_OPCOUNT_EN
      obs_cnt = int'(op_cnt);
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; len_a = '0; len_b = '0; bus.op_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", bus.rd_en); end
      checks++; if (bus.rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got %0d want 0", bus.rd_addr); end
      checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got %b want 0", bus.op_valid); end
      checks++; if (bus.op_code !== 2'b00) begin errors++; $display("FAIL reset_op_code got %b want 00", bus.op_code); end
      checks++; if (bus.op_i !== '0 || bus.op_j !== '0) begin errors++; $display("FAIL reset_op_ij got %0d,%0d want 0,0", bus.op_i, bus.op_j); end
      checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_status got busy=%b done=%b err=%b want 000", busy, done, err); end
`ifdef TB_OPCOUNT_EN
      checks++; if (op_cnt !== '0) begin errors++; $display("FAIL reset_op_cnt got %0d want 0", op_cnt); end
`endif
      rst = 1'b0;
   endtask

   // Directed walks: all-diag 3x3, column-only, mixed priority, empty, full-size matrix
   task automatic test_fixed_walks();
      int la_t [5] = '{3, 2, 1, 0, 128};
      int lb_t [5] = '{3, 0, 3, 0, 128};
      for (int c = 0; c < 5; c++) begin
         fill_mem(0);
         if (c == 0) begin
            mem[3 * (N + 1) + 3] = 3'b100; mem[2 * (N + 1) + 2] = 3'b100; mem[1 * (N + 1) + 1] = 3'b100;
         end
         if (c == 2) begin
            mem[1 * (N + 1) + 3] = 3'b001; mem[1 * (N + 1) + 2] = 3'b110;
         end
         model_walk(la_t[c], lb_t[c]);
         drive_walk(la_t[c], lb_t[c], 100, 0);
         checks++; if (timed_out !== 0) begin errors++; $display("FAIL fixed%0d_timeout got no done want done", c); end
         checks++; if (done_cnt !== 1) begin errors++; $display("FAIL fixed%0d_done_pulses got %0d want 1", c, done_cnt); end
         checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL fixed%0d_err got %b want 0", c, err_at_done); end
         checks++; if (busy_bad !== 0) begin errors++; $display("FAIL fixed%0d_busy got %0d bad cycles want 0", c, busy_bad); end
         checks++; if (obs_ops.size() !== exp_ops.size()) begin errors++; $display("FAIL fixed%0d_op_count got %0d want %0d", c, obs_ops.size(), exp_ops.size()); end
         for (int k = 0; k < exp_ops.size() && k < obs_ops.size(); k++) begin
            checks++; if (obs_ops[k] !== exp_ops[k]) begin errors++; $display("FAIL fixed%0d_op%0d got %h want %h", c, k, obs_ops[k], exp_ops[k]); end
         end
         checks++; if (obs_rd.size() !== exp_rd.size()) begin errors++; $display("FAIL fixed%0d_read_count got %0d want %0d", c, obs_rd.size(), exp_rd.size()); end
         for (int k = 0; k < exp_rd.size() && k < obs_rd.size(); k++) begin
            checks++; if (obs_rd[k] !== exp_rd[k]) begin errors++; $display("FAIL fixed%0d_rd_addr%0d got %0d want %0d", c, k, obs_rd[k], exp_rd[k]); end
         end
`ifdef TB_OPCOUNT_EN
         checks++; if (obs_cnt !== exp_ops.size()) begin errors++; $display("FAIL fixed%0d_op_cnt got %0d want %0d", c, obs_cnt, exp_ops.size()); end
`endif
      end
   endtask

   task automatic test_stall();
      fill_mem(0);
      model_walk(4, 4);
      drive_walk(4, 4, 100, 5);
      checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", stall_bad); end
      checks++; if (obs_ops.size() !== exp_ops.size()) begin errors++; $display("FAIL stall_op_count got %0d want %0d", obs_ops.size(), exp_ops.size()); end
      for (int k = 0; k < exp_ops.size() && k < obs_ops.size(); k++) begin
         checks++; if (obs_ops[k] !== exp_ops[k]) begin errors++; $display("FAIL stall_op%0d got %h want %h", k, obs_ops[k], exp_ops[k]); end
      end
      checks++; if (obs_rd.size() !== exp_rd.size()) begin errors++; $display("FAIL stall_read_count got %0d want %0d", obs_rd.size(), exp_rd.size()); end
   endtask

   task automatic test_bad_word();
      fill_mem(0);
      mem[4 * (N + 1) + 5] = 3'b000;
      drive_walk(4, 5, 100, 0);
      checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL bad_first_err got %b want 1", err_at_done); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bad_first_done got %0d want 1", done_cnt); end
      checks++; if (valid_seen !== 0) begin errors++; $display("FAIL bad_first_op_valid got %0d cycles want 0", valid_seen); end
      checks++; if (obs_rd.size() !== 1) begin errors++; $display("FAIL bad_first_reads got %0d want 1", obs_rd.size()); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err_sticky got %b want 1", err); end
      mem[3 * (N + 1) + 3] = 3'b100; mem[2 * (N + 1) + 2] = 3'b000;
      model_walk(3, 3);
      drive_walk(3, 3, 100, 0);
      checks++; if (err_at_done !== exp_err) begin errors++; $display("FAIL bad_deep_err got %b want %b", err_at_done, exp_err); end
      checks++; if (obs_ops.size() !== exp_ops.size()) begin errors++; $display("FAIL bad_deep_op_count got %0d want %0d", obs_ops.size(), exp_ops.size()); end
      fill_mem(0);
      model_walk(2, 3);
      drive_walk(2, 3, 100, 0);
      checks++; if (err_after_start !== 1'b0) begin errors++; $display("FAIL bad_err_clear got %b want 0", err_after_start); end
      checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL bad_clean_err got %b want 0", err_at_done); end
      checks++; if (obs_ops.size() !== exp_ops.size()) begin errors++; $display("FAIL bad_clean_op_count got %0d want %0d", obs_ops.size(), exp_ops.size()); end
   endtask

   task automatic test_reset_mid_walk();
      int dn = 0;
      fill_mem(0);
      @(negedge clk);
      start = 1'b1; len_a = IW'(10); len_b = IW'(10); bus.op_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (done) dn++;
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.rd_en, bus.rd_addr, bus.op_valid, bus.op_code, bus.op_i, bus.op_j, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL midrst_outputs got rd_en=%b addr=%0d valid=%b code=%b i=%0d j=%0d busy=%b done=%b err=%b want all 0",
                  bus.rd_en, bus.rd_addr, bus.op_valid, bus.op_code, bus.op_i, bus.op_j, busy, done, err);
      end
      checks++; if (dn !== 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", dn); end
      rst = 1'b0; bus.op_ready = 1'b0;
      model_walk(10, 10);
      drive_walk(10, 10, 80, 0);
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL midrst_rewalk_done got %0d want 1", done_cnt); end
      checks++; if (obs_ops.size() !== exp_ops.size()) begin errors++; $display("FAIL midrst_rewalk_op_count got %0d want %0d", obs_ops.size(), exp_ops.size()); end
      for (int k = 0; k < exp_ops.size() && k < obs_ops.size(); k++) begin
         checks++; if (obs_ops[k] !== exp_ops[k]) begin errors++; $display("FAIL midrst_rewalk_op%0d got %h want %h", k, obs_ops[k], exp_ops[k]); end
      end
   endtask

   task automatic test_random();
      int la;
      int lb;
      for (int t = 0; t < 10; t++) begin
         la = int'($urandom_range(0, 20));
         lb = int'($urandom_range(0, 20));
         fill_mem(5);
         model_walk(la, lb);
         drive_walk(la, lb, 70, 0);
         checks++; if (timed_out !== 0 || done_cnt !== 1) begin errors++; $display("FAIL rand%0d_done got timeout=%0d pulses=%0d want 0,1", t, timed_out, done_cnt); end
         checks++; if (err_at_done !== exp_err) begin errors++; $display("FAIL rand%0d_err got %b want %b", t, err_at_done, exp_err); end
         checks++; if (stall_bad !== 0 || busy_bad !== 0) begin errors++; $display("FAIL rand%0d_hold got stall=%0d busy=%0d want 0,0", t, stall_bad, busy_bad); end
         checks++; if (obs_ops.size() !== exp_ops.size()) begin errors++; $display("FAIL rand%0d_op_count got %0d want %0d", t, obs_ops.size(), exp_ops.size()); end
         for (int k = 0; k < exp_ops.size() && k < obs_ops.size(); k++) begin
            checks++; if (obs_ops[k] !== exp_ops[k]) begin errors++; $display("FAIL rand%0d_op%0d got %h want %h", t, k, obs_ops[k], exp_ops[k]); end
         end
         checks++; if (obs_rd.size() !== exp_rd.size()) begin errors++; $display("FAIL rand%0d_read_count got %0d want %0d", t, obs_rd.size(), exp_rd.size()); end
         for (int k = 0; k < exp_rd.size() && k < obs_rd.size(); k++) begin
            checks++; if (obs_rd[k] !== exp_rd[k]) begin errors++; $display("FAIL rand%0d_rd_addr%0d got %0d want %0d", t, k, obs_rd[k], exp_rd[k]); end
         end
`ifdef TB_OPCOUNT_EN
         checks++; if (obs_cnt !== exp_ops.size()) begin errors++; $display("FAIL rand%0d_op_cnt got %0d want %0d", t, obs_cnt, exp_ops.size()); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_fixed_walks();
      test_stall();
      test_bad_word();
      test_reset_mid_walk();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
